// File: rtl/karatsuba2_gf2_serial_pkg.sv
// Shared types and derived-constant helpers for the two-way Karatsuba
// GF(2) multiplier. Module parameters feed the helper functions, so every
// file derives L, H, N and the counter width the same way.
package karatsuba2_gf2_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL     = 2'd1,
    ST_COMBINE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Low half width L = floor(W/2)
  function automatic int k2_l(input int width);
    return width / 2;
  endfunction

  // High half width H = W - L; the low half is zero-extended to this
  function automatic int k2_h(input int width);
    return width - width / 2;
  endfunction

  // Digit steps per sub-product N = ceil(H/DIGIT)
  function automatic int k2_n(input int width, input int digit);
    return (k2_h(width) + digit - 1) / digit;
  endfunction

  // Counter must hold 0..N
  function automatic int k2_cw(input int width, input int digit);
    return clog2(k2_n(width, digit) + 1);
  endfunction

  localparam int DEF_WIDTH = 233;
  localparam int DEF_DIGIT = 1;
  localparam int DEF_L     = k2_l(DEF_WIDTH);
  localparam int DEF_H     = k2_h(DEF_WIDTH);
  localparam int DEF_N     = k2_n(DEF_WIDTH, DEF_DIGIT);

endpackage

// File: rtl/karatsuba2_gf2_serial_mul.sv
// Digit-serial carry-less multiplier, LSB digit first. The first enabled
// cycle after clr captures x/y into shift registers; each later enabled
// cycle XORs in DIGIT shifted copies of x and advances both shifters.
// Multiplier bits shifted past the top of y come in as 0, so a short
// final digit contributes nothing extra.
module gf2_digit_serial_mul #(
  parameter int H     = 117,
  parameter int DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  input  logic [H-1:0]   x,
  input  logic [H-1:0]   y,
  output logic [2*H-2:0] p
);
  localparam int PW = 2*H-1;

  logic          r_ld;
  logic [PW-1:0] r_xs;
  logic [H-1:0]  r_ys;
  logic [PW-1:0] r_acc;
  logic [PW-1:0] w_pp;

  // Partial product of the current digit: XOR of shifted multiplicands
  always_comb begin
    w_pp = '0;
    for (int j = 0; j < DIGIT; j++) begin
      if (r_ys[j]) w_pp = w_pp ^ (r_xs << j);
    end
  end

  // Load on first enable, then accumulate one digit per enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ld  <= 1'b0;
      r_xs  <= '0;
      r_ys  <= '0;
      r_acc <= '0;
    end else if (clr) begin
      r_ld  <= 1'b0;
      r_xs  <= '0;
      r_ys  <= '0;
      r_acc <= '0;
    end else if (en) begin
      if (!r_ld) begin
        r_ld <= 1'b1;
        r_xs <= PW'(x);
        r_ys <= y;
      end else begin
        r_acc <= r_acc ^ w_pp;
        r_xs  <= r_xs << DIGIT;
        r_ys  <= r_ys >> DIGIT;
      end
    end
  end

  assign p = r_acc;

endmodule

// File: rtl/karatsuba2_gf2_serial.sv
// Two-way Karatsuba GF(2) polynomial multiplier. Three digit-serial
// sub-multipliers run in parallel on the operand halves; the top holds
// the control FSM, operand registers and the combine/output register.
module karatsuba2_gf2_serial
  import karatsuba2_gf2_serial_pkg::*;
#(
  parameter int WIDTH = 233,
  parameter int DIGIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] c
);
  localparam int L    = k2_l(WIDTH);
  localparam int H    = k2_h(WIDTH);
  localparam int N    = k2_n(WIDTH, DIGIT);
  localparam int CW   = k2_cw(WIDTH, DIGIT);
  localparam int PW   = 2*H-1;
  localparam int CWID = 2*WIDTH;

  state_t           r_state, w_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b;
  logic [CWID-1:0]  r_c;
  logic             w_accept, w_en, w_last;
  logic [H-1:0]     w_ah, w_al, w_bh, w_bl, w_am, w_bm;
  logic [PW-1:0]    w_phh, w_pll, w_pm;
  logic [CWID-1:0]  w_c;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_en     = (r_state == ST_MUL);
  // MUL cycle 0 loads the sub-multipliers; cycles 1..N each eat one digit
  assign w_last   = (r_cnt == CW'(N));

  assign w_ah = r_a[WIDTH-1:L];
  assign w_al = H'(r_a[L-1:0]);
  assign w_bh = r_b[WIDTH-1:L];
  assign w_bl = H'(r_b[L-1:0]);
  assign w_am = w_ah ^ w_al;
  assign w_bm = w_bh ^ w_bl;

  gf2_digit_serial_mul #(.H(H), .DIGIT(DIGIT)) u_mul_hh (
    .clk(clk), .rst(rst), .clr(w_accept), .en(w_en), .x(w_ah), .y(w_bh), .p(w_phh)
  );
  gf2_digit_serial_mul #(.H(H), .DIGIT(DIGIT)) u_mul_ll (
    .clk(clk), .rst(rst), .clr(w_accept), .en(w_en), .x(w_al), .y(w_bl), .p(w_pll)
  );
  gf2_digit_serial_mul #(.H(H), .DIGIT(DIGIT)) u_mul_m (
    .clk(clk), .rst(rst), .clr(w_accept), .en(w_en), .x(w_am), .y(w_bm), .p(w_pm)
  );

  // Karatsuba recombination; the middle term is pure XOR in GF(2)
  assign w_c = (CWID'(w_phh) << (2*L))
             ^ (CWID'(w_pm ^ w_phh ^ w_pll) << L)
             ^ CWID'(w_pll);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_nxt;
  end

  // Next-state logic
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (start)  w_nxt = ST_MUL;
      ST_MUL:     if (w_last) w_nxt = ST_COMBINE;
      ST_COMBINE: w_nxt = ST_DONE;
      ST_DONE:    w_nxt = ST_IDLE;
      default:    w_nxt = ST_IDLE;
    endcase
  end

  // Operand capture on accept and MUL cycle counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_a   <= a;
      r_b   <= b;
    end else if (w_en && !w_last) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Result register: written only in COMBINE, held otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      r_c <= '0;
    else if (r_state == ST_COMBINE) r_c <= w_c;
  end

  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);
  assign c    = r_c;

endmodule

// File: tb/tb_karatsuba2_gf2_serial.sv
// Scoreboard bench: the driver pushes the reference product and accept
// cycle on every accepted start; a monitor on the falling edge pops on
// done and otherwise checks that c holds its last completed value.
module tb_karatsuba2_gf2_serial;
  localparam int W   = 233;
  localparam int D   = 5;
  localparam int W2  = 2*W;
  localparam int HH  = W - W/2;
  localparam int NN  = (HH + D - 1) / D;
  localparam int LAT = NN + 2;

  logic          clk, rst, start;
  logic [W-1:0]  a, b;
  logic          busy, done;
  logic [W2-1:0] c;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [W2-1:0] exp_q[$];
  int            acc_q[$];

  karatsuba2_gf2_serial #(.WIDTH(W), .DIGIT(D)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .c(c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: schoolbook carry-less multiply straight from the definition
  function automatic logic [W2-1:0] clmul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W2-1:0] r, xe;
    r  = '0;
    xe = W2'(x);
    for (int i = 0; i < W; i++) if (y[i]) r = r ^ (xe << i);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] r;
    int mode;
    mode = $urandom_range(0, 9);
    for (int i = 0; i < W; i++) begin
      if (mode == 0)      r[i] = ($urandom_range(0, 31) == 0);
      else if (mode == 1) r[i] = ($urandom_range(0, 31) != 0);
      else                r[i] = 1'($urandom_range(0, 1));
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [W2-1:0] act, input logic [W2-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, expv);
    end
  endtask

  // Wait for IDLE, present operands, and record the accept
  task automatic accept_op(input logic [W-1:0] ta, input logic [W-1:0] tbv);
    int g;
    g = 0;
    while (busy !== 1'b0 && g < 200) begin @(posedge clk); #1; g++; end
    if (g >= 200) begin n_cmp++; n_err++; $display("FAIL idle_wait: busy=%b after %0d cycles", busy, g); end
    a = ta; b = tbv; start = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(clmul(ta, tbv));
    acc_q.push_back(cyc);
    start = 1'b0;
    chk("busy_after_accept", W2'(busy), W2'(1));
  endtask

  // Run until IDLE; optionally scramble inputs and poke start meanwhile
  task automatic drain(input bit noisy);
    int g;
    g = 0;
    while (busy !== 1'b0 && g < 200) begin
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        a = rnd_op(); b = rnd_op();
      end
      @(posedge clk); #1; g++;
    end
    start = 1'b0;
    if (g >= 200) begin n_cmp++; n_err++; $display("FAIL drain: busy=%b after %0d cycles", busy, g); end
  endtask

  // Monitor
  initial begin
    logic [W2-1:0] hold, e;
    int ac;
    hold = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        hold = '0;
      end else if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_done: c=%h with nothing pending", c);
        end else begin
          e  = exp_q.pop_front();
          ac = acc_q.pop_front();
          chk("product", c, e);
          chk("latency", W2'(cyc - ac), W2'(LAT));
          chk("busy_in_done", W2'(busy), W2'(1));
          hold = e;
        end
      end else begin
        chk("c_hold", c, hold);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ones, msb, x1, y1, x2, y2;
    ones = '1;
    msb  = '0; msb[W-1] = 1'b1;
    rst = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", W2'(busy), '0);
    chk("reset_done", W2'(done), '0);
    chk("reset_c", c, '0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed corners
    accept_op(msb, msb);           drain(0);
    accept_op('0, ones);           drain(0);
    accept_op(W'(3), W'(3));       drain(1);
    accept_op(W'(8'hFF), W'(1));   drain(1);
    accept_op(ones, ones);         drain(1);
    accept_op(ones, msb);          drain(0);

    // Start held high: exactly one IDLE cycle between done and next accept
    x1 = rnd_op(); y1 = rnd_op(); x2 = rnd_op(); y2 = rnd_op();
    a = x1; b = y1; start = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(clmul(x1, y1)); acc_q.push_back(cyc);
    repeat (LAT) begin a = rnd_op(); b = rnd_op(); @(posedge clk); #1; end
    @(posedge clk); #1;
    a = x2; b = y2;
    @(posedge clk); #1;
    exp_q.push_back(clmul(x2, y2)); acc_q.push_back(cyc);
    start = 1'b0;
    drain(1);

    // Random operands with start noise while busy
    for (int k = 0; k < 1200; k++) begin
      accept_op(rnd_op(), rnd_op());
      drain(k[0]);
    end

    // Reset in the middle of MUL: abort, no done, c cleared
    accept_op(rnd_op() | W'(1), rnd_op() | W'(1));
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete(); acc_q.delete();
    #1;
    chk("midreset_busy", W2'(busy), '0);
    chk("midreset_done", W2'(done), '0);
    chk("midreset_c", c, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    accept_op(W'(3), W'(5));
    drain(0);
    chk("post_reset_c", c, W2'(16'hF));

    repeat (5) @(posedge clk);
    #1;
    chk("pending", W2'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
